prbs_word_checker: RTL and testbench

Receive-side checker for the 32-bit LFSR stream produced by the team's pseudo-random generator.
- Polynomial taps 31/30/29/9, shift-left, feedback into bit 0.
- Each valid input word is one full LFSR state.
- The block self-synchronises onto the stream, predicts each next state and flags matches and mismatches.
- It maintains lock status and a saturating error count.
- It sits at the consumer end of any link or bus carrying raw LFSR states, and is used for link BIST and generator verification.

---
 rtl/prbs_word_checker_pkg.sv | 27 ++
 rtl/prbs_word_checker_step.sv | 11 +
 rtl/prbs_word_checker.sv | 108 ++++++++++
 tb/tb_prbs_word_checker.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/prbs_word_checker_pkg.sv
// Shared definitions for the 32-bit PRBS generator and checker pair.
// Both ends take the polynomial from here so they cannot drift apart.
package prbs_word_checker_pkg;

    localparam int LFSR_WIDTH = 32;
    localparam int TAP_A      = 31;
    localparam int TAP_B      = 30;
    localparam int TAP_C      = 29;
    localparam int TAP_D      = 9;

    localparam logic [LFSR_WIDTH-1:0] DEFAULT_SEED = 32'hACE1_2468;
    localparam logic [LFSR_WIDTH-1:0] TAP_MASK =
        (LFSR_WIDTH'(1) << TAP_A) | (LFSR_WIDTH'(1) << TAP_B) |
        (LFSR_WIDTH'(1) << TAP_C) | (LFSR_WIDTH'(1) << TAP_D);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    // Shift left, XOR of the tapped bits enters at bit 0.
    function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] s);
        return {s[LFSR_WIDTH-2:0], ^(s & TAP_MASK)};
    endfunction

endpackage

// File: rtl/prbs_word_checker_step.sv
// Combinational single-step LFSR advance, instantiated by generator and checker.
module lfsr32_step
    import prbs_word_checker_pkg::*;
(
    input  logic [LFSR_WIDTH-1:0] state,
    output logic [LFSR_WIDTH-1:0] next_state
);

    assign next_state = lfsr_next(state);

endmodule

// File: rtl/prbs_word_checker.sv
// Self-synchronising checker for the raw 32-bit LFSR state stream:
// acquires, tracks lock and counts mismatches seen while locked.
module prbs_word_checker
    import prbs_word_checker_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int ERR_W      = 16
) (
    input  logic                  iClock,
    input  logic                  iReset,
    input  logic                  iValid,
    input  logic [LFSR_WIDTH-1:0] iData,
    input  logic                  iClearErr,
    output logic                  oLocked,
    output logic                  oMatch,
    output logic                  oMismatch,
    output logic [ERR_W-1:0]      oErrorCount,
    output logic [LFSR_WIDTH-1:0] oExpected
);

    localparam logic [3:0]       GOOD_LAST = 4'(LOCK_COUNT - 1);
    localparam logic [3:0]       BAD_LAST  = 4'(LOSS_COUNT - 1);
    localparam logic [ERR_W-1:0] ERR_ONE   = {{(ERR_W-1){1'b0}}, 1'b1};

    chk_state_t            state;
    logic [3:0]            good_run;
    logic [3:0]            bad_run;
    logic [LFSR_WIDTH-1:0] data_next;
    logic [LFSR_WIDTH-1:0] exp_next;
    logic                  hit;
    logic                  zero_in;

    lfsr32_step u_data_step (.state(iData),     .next_state(data_next));
    lfsr32_step u_exp_step  (.state(oExpected), .next_state(exp_next));

    assign hit     = (iData == oExpected);
    assign zero_in = (iData == '0);

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state       <= SEARCH;
            good_run    <= '0;
            bad_run     <= '0;
            oLocked     <= 1'b0;
            oMatch      <= 1'b0;
            oMismatch   <= 1'b0;
            oErrorCount <= '0;
            oExpected   <= '0;
        end else begin
            oMatch    <= 1'b0;
            oMismatch <= 1'b0;
            if (iValid) begin
                case (state)
                    SEARCH: begin
                        // All-zero is the LFSR lockup state and can never seed a stream.
                        if (!zero_in) begin
                            oExpected <= data_next;
                            good_run  <= '0;
                            state     <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (hit) begin
                            oMatch    <= 1'b1;
                            oExpected <= data_next;
                            if (good_run == GOOD_LAST) begin
                                state    <= LOCKED;
                                oLocked  <= 1'b1;
                                good_run <= '0;
                                bad_run  <= '0;
                            end else begin
                                good_run <= good_run + 4'd1;
                            end
                        end else begin
                            oMismatch <= 1'b1;
                            good_run  <= '0;
                            if (zero_in) state <= SEARCH;
                            else         oExpected <= data_next;
                        end
                    end
                    LOCKED: begin
                        // Free-run the prediction so one bad word does not reseed it.
                        oExpected <= exp_next;
                        if (hit) begin
                            oMatch  <= 1'b1;
                            bad_run <= '0;
                        end else begin
                            oMismatch <= 1'b1;
                            if (oErrorCount != '1) oErrorCount <= oErrorCount + ERR_ONE;
                            if (bad_run == BAD_LAST) begin
                                state   <= SEARCH;
                                oLocked <= 1'b0;
                                bad_run <= '0;
                            end else begin
                                bad_run <= bad_run + 4'd1;
                            end
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
            // Clear wins over a same-cycle increment.
            if (iClearErr) oErrorCount <= '0;
        end
    end

endmodule

// File: tb/tb_prbs_word_checker.sv
// Scoreboarded bench for prbs_word_checker plus a narrow-counter instance for saturation.
module tb_prbs_word_checker;

    logic        gclk = 1'b0;
    logic        rst = 1'b1;
    logic        vld = 1'b0;
    logic [31:0] dat = '0;
    logic        clr = 1'b0;

    logic        lk0, m0, mm0;
    logic [15:0] err0;
    logic [31:0] ex0;
    logic        lk1, m1, mm1;
    logic [3:0]  err1;
    logic [31:0] ex1;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct {
        int          due;
        logic        m;
        logic        mm;
        logic        lk;
        logic [15:0] err;
        logic [31:0] ex;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    logic [31:0] s;

    always #5 gclk = ~gclk;
    always @(posedge gclk) cyc <= cyc + 1;

    prbs_word_checker u_dut (
        .iClock(gclk), .iReset(rst), .iValid(vld), .iData(dat), .iClearErr(clr),
        .oLocked(lk0), .oMatch(m0), .oMismatch(mm0), .oErrorCount(err0), .oExpected(ex0)
    );

    prbs_word_checker #(.LOCK_COUNT(4), .LOSS_COUNT(15), .ERR_W(4)) u_sat (
        .iClock(gclk), .iReset(rst), .iValid(vld), .iData(dat), .iClearErr(clr),
        .oLocked(lk1), .oMatch(m1), .oMismatch(mm1), .oErrorCount(err1), .oExpected(ex1)
    );

    function automatic logic [31:0] nxt(input logic [31:0] v);
        return {v[30:0], v[31] ^ v[30] ^ v[29] ^ v[9]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock of stimulus; optionally queue what the main DUT must show after it.
    task automatic drv(input logic r, input logic v, input logic [31:0] d, input logic c,
                       input logic sb, input logic xm, input logic xmm, input logic xlk,
                       input logic [15:0] xerr, input logic [31:0] xex, input string tag);
        exp_t t;
        rst = r; vld = v; dat = d; clr = c;
        if (sb) begin
            t.due = cyc + 1; t.m = xm; t.mm = xmm; t.lk = xlk;
            t.err = xerr; t.ex = xex; t.tag = tag;
            sb_q.push_back(t);
        end
        @(posedge gclk);
        #1;
    endtask

    always @(negedge gclk) begin
        while (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            e = sb_q.pop_front();
            chk({e.tag, ".match"},    32'(m0),   32'(e.m));
            chk({e.tag, ".mismatch"}, 32'(mm0),  32'(e.mm));
            chk({e.tag, ".locked"},   32'(lk0),  32'(e.lk));
            chk({e.tag, ".err"},      32'(err0), 32'(e.err));
            chk({e.tag, ".expected"}, ex0,       e.ex);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        @(posedge gclk); #1;
        drv(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, "rst0");
        drv(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, "rst1");

        // Acquisition from the default seed
        s = 32'hACE1_2468;
        drv(0, 1, s, 0, 1, 0, 0, 0, 0, nxt(s), "cap");
        s = nxt(s);
        chk("seed_step", s, 32'h59C2_48D0);
        for (int i = 1; i <= 4; i++) begin
            drv(0, 1, s, 0, 1, 1, 0, (i == 4), 0, nxt(s), $sformatf("acq%0d", i));
            s = nxt(s);
        end

        // Single corrupted word while locked
        drv(0, 1, s, 0, 1, 1, 0, 1, 0, nxt(s), "lk_good");      s = nxt(s);
        drv(0, 1, s ^ 32'h1, 0, 1, 0, 1, 1, 1, nxt(s), "lk_bad"); s = nxt(s);
        drv(0, 1, s, 0, 1, 1, 0, 1, 1, nxt(s), "lk_recover");   s = nxt(s);

        // Idle cycle with clear: pulses drop, prediction holds, lock kept
        drv(0, 0, 32'hDEAD_BEEF, 1, 1, 0, 0, 1, 0, s, "idle_clr");

        // Three consecutive bad words drop lock
        for (int i = 1; i <= 3; i++) begin
            drv(0, 1, s ^ 32'h8000_0000, 0, 1, 0, 1, (i < 3), 16'(i), nxt(s), $sformatf("loss%0d", i));
            s = nxt(s);
        end
        drv(0, 1, s, 0, 1, 0, 0, 0, 3, nxt(s), "re_cap"); s = nxt(s);
        for (int i = 1; i <= 4; i++) begin
            drv(0, 1, s, 0, 1, 1, 0, (i == 4), 3, nxt(s), $sformatf("relock%0d", i));
            s = nxt(s);
        end

        // VERIFY: mismatch reseeds, zero word returns to SEARCH
        drv(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, "rst2");
        drv(0, 1, s, 0, 1, 0, 0, 0, 0, nxt(s), "v_cap");
        drv(0, 1, s ^ 32'h5, 0, 1, 0, 1, 0, 0, nxt(s ^ 32'h5), "v_bad");
        drv(0, 1, 0, 0, 1, 0, 1, 0, 0, nxt(s ^ 32'h5), "v_zero");
        drv(0, 1, 0, 0, 1, 0, 0, 0, 0, nxt(s ^ 32'h5), "s_zero");

        // Zeros ignored in SEARCH, then capture and lock from 0x59C248D0
        drv(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, "rst3");
        for (int i = 0; i < 3; i++)
            drv(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, $sformatf("zero%0d", i));
        s = 32'h59C2_48D0;
        drv(0, 1, s, 0, 1, 0, 0, 0, 0, nxt(s), "z_cap"); s = nxt(s);
        for (int i = 1; i <= 4; i++) begin
            drv(0, 1, s, 0, 1, 1, 0, (i == 4), 0, nxt(s), $sformatf("z_acq%0d", i));
            s = nxt(s);
        end

        // Reset while locked and valid, then first word after reset is a capture
        drv(1, 1, s, 0, 1, 0, 0, 0, 0, 0, "rst_lk"); s = nxt(s);
        drv(0, 1, s, 0, 1, 0, 0, 0, 0, nxt(s), "post_rst"); s = nxt(s);

        // Saturation on the 4-bit-counter instance
        drv(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, "rst4");
        for (int i = 0; i < 5; i++) begin
            drv(0, 1, s, 0, 0, 0, 0, 0, 0, 0, "sat_acq"); s = nxt(s);
        end
        chk("sat.locked", 32'(lk1), 1);
        for (int i = 0; i < 10; i++) begin
            drv(0, 1, s ^ 32'h1, 0, 0, 0, 0, 0, 0, 0, "sat_bad"); s = nxt(s);
        end
        chk("sat.err10", 32'(err1), 10);
        drv(0, 1, s, 0, 0, 0, 0, 0, 0, 0, "sat_good"); s = nxt(s);
        chk("sat.match", 32'(m1), 1);
        for (int i = 0; i < 10; i++) begin
            drv(0, 1, s ^ 32'h1, 0, 0, 0, 0, 0, 0, 0, "sat_bad"); s = nxt(s);
        end
        chk("sat.err_full", 32'(err1), 15);
        chk("sat.still_locked", 32'(lk1), 1);
        drv(0, 1, s ^ 32'h1, 0, 0, 0, 0, 0, 0, 0, "sat_more"); s = nxt(s);
        chk("sat.err_hold", 32'(err1), 15);
        chk("sat.expected", ex1, s);
        drv(0, 1, s ^ 32'h1, 1, 0, 0, 0, 0, 0, 0, "sat_clr"); s = nxt(s);
        chk("sat.err_cleared", 32'(err1), 0);
        chk("sat.clr_mismatch", 32'(mm1), 1);
        chk("sat.clr_locked", 32'(lk1), 1);

        vld = 0; clr = 0;
        repeat (3) @(posedge gclk);
        #1;
        chk("sb_drained", 32'(sb_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
